// File: rtl/uart_msg_arbiter_if.sv
// Handshake bundle between the message sources, the arbiter and the shared uart_tx.
// Latency: none, wires only.
// Backpressure: in_ready/tx_ready carry it; no storage here.
interface uart_msg_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [8*N_REQ-1:0] in_data;
    logic [N_REQ-1:0]   in_valid;
    logic [N_REQ-1:0]   in_last;
    logic [N_REQ-1:0]   in_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               abort;

    modport master (
        output req, in_data, in_valid, in_last, tx_ready,
        input  gnt, in_ready, tx_data, tx_valid, busy, abort
    );

    modport slave (
        input  req, in_data, in_valid, in_last, tx_ready,
        output gnt, in_ready, tx_data, tx_valid, busy, abort
    );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ sources, one grant per whole message.
// Latency: grant 1 cycle after req in IDLE; an accepted byte pulses tx_valid on the next cycle.
// Backpressure: in_ready only to the granted source while uart idle and no pulse in flight; stalls time out.
module uart_msg_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    uart_msg_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    g_idx;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    g_next;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [CW-1:0]    stall_cnt;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;
    logic             abort;
    logic             accept;
    logic             stall;

    // First requester found searching ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && bus.req[(int'(ptr) + k) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign g_next = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);

    // The !tx_valid term gives uart_tx one cycle to drop tx_ready after each pulse.
    assign accept = (state == SEND) && bus.in_valid[g_idx] && bus.tx_ready && !tx_valid;
    assign stall  = (state == SEND) && !bus.in_valid[g_idx] && bus.tx_ready && !tx_valid;

    assign bus.in_ready = accept ? gnt : '0;
    assign bus.gnt      = gnt;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.busy     = busy;
    assign bus.abort    = abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            g_idx     <= '0;
            ptr       <= '0;
            stall_cnt <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            abort    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt       <= N_REQ'(1) << pick_idx;
                        g_idx     <= pick_idx;
                        busy      <= 1'b1;
                        stall_cnt <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        tx_data   <= bus.in_data[int'(g_idx) * 8 +: 8];
                        tx_valid  <= 1'b1;
                        stall_cnt <= '0;
                        if (bus.in_last[g_idx]) begin
                            gnt   <= '0;
                            busy  <= 1'b0;
                            ptr   <= g_next;
                            state <= IDLE;
                        end
                    end else if (stall) begin
                        if (stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            abort     <= 1'b1;
                            gnt       <= '0;
                            busy      <= 1'b0;
                            ptr       <= g_next;
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter: round-robin table plus hand sequences for timeout and reset.
module tb_uart_msg_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_msg_arbiter_if #(.N_REQ(N)) ifc ();
    uart_msg_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int n_chk  = 0;
    int n_pass = 0;
    int uart_hold = 0;
    int hold_left = 0;
    int proto_bad = 0;
    int rdy_cnt[N];
    logic prev_txv = 1'b0;
    logic [7:0] tx_log[$];
    logic [7:0] exp_tx[$];

    typedef struct {
        logic [N-1:0] req;
        int           src;
        logic [N-1:0] exp_gnt;
        logic [7:0]   b0;
        logic [7:0]   b1;
    } rnd_t;
    rnd_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Offer one byte from src at a negedge; returns at the negedge after it is accepted.
    task automatic send_byte(input int src, input logic [7:0] d, input logic last);
        bit got;
        got = 1'b0;
        ifc.in_data[src*8 +: 8] = d;
        ifc.in_valid[src] = 1'b1;
        ifc.in_last[src]  = last;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (ifc.in_ready[src]) got = 1'b1;
            else @(negedge clk);
        end
        if (got) begin
            @(negedge clk);
            exp_tx.push_back(d);
        end
        ifc.in_valid[src] = 1'b0;
        ifc.in_last[src]  = 1'b0;
        chk($sformatf("accept_src%0d_%02h", src, d), {31'd0, got}, 32'd1);
    endtask

    // uart_tx model: tx_ready drops for uart_hold cycles after each start pulse.
    initial begin
        ifc.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ifc.tx_valid) hold_left = uart_hold;
            if (hold_left > 0) begin
                ifc.tx_ready = 1'b0;
                hold_left--;
            end else begin
                ifc.tx_ready = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (ifc.tx_valid) tx_log.push_back(ifc.tx_data);
            if (ifc.tx_valid && prev_txv) proto_bad++;
            prev_txv = ifc.tx_valid;
            if (!$onehot0(ifc.gnt)) proto_bad++;
            if ((ifc.in_ready & ~ifc.gnt) != '0) proto_bad++;
            if (ifc.in_ready != '0 && !ifc.tx_ready) proto_bad++;
            for (int i = 0; i < N; i++) if (ifc.in_ready[i]) rdy_cnt[i]++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, nlog, ab_cnt, ab_at, mism;
        logic [N-1:0] ab_gnt, nxt_gnt;
        logic ab_busy;
        logic [7:0] msg[3];

        tbl[0]  = '{4'b1011, 0, 4'b0001, 8'hA0, 8'hA1};
        tbl[1]  = '{4'b1011, 1, 4'b0010, 8'hB0, 8'hB1};
        tbl[2]  = '{4'b1011, 3, 4'b1000, 8'hC0, 8'hC1};
        tbl[3]  = '{4'b1011, 0, 4'b0001, 8'hA2, 8'hA3};
        tbl[4]  = '{4'b1011, 1, 4'b0010, 8'hB2, 8'hB3};
        tbl[5]  = '{4'b1011, 3, 4'b1000, 8'hC2, 8'hC3};
        tbl[6]  = '{4'b0101, 0, 4'b0001, 8'h01, 8'h02};
        tbl[7]  = '{4'b0101, 2, 4'b0100, 8'h21, 8'h22};
        tbl[8]  = '{4'b0101, 0, 4'b0001, 8'h03, 8'h04};
        tbl[9]  = '{4'b0101, 2, 4'b0100, 8'h23, 8'h24};
        tbl[10] = '{4'b1000, 3, 4'b1000, 8'h31, 8'h32};
        tbl[11] = '{4'b0110, 1, 4'b0010, 8'h11, 8'h12};
        tbl[12] = '{4'b0110, 2, 4'b0100, 8'h25, 8'h26};
        tbl[13] = '{4'b0001, 0, 4'b0001, 8'h05, 8'h06};
        tbl[14] = '{4'b1001, 3, 4'b1000, 8'h33, 8'h34};

        rst = 1'b1;
        ifc.req = '0;
        ifc.in_valid = '0;
        ifc.in_last = '0;
        ifc.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", ifc.gnt, 0);
        chk("rst_tx_valid", ifc.tx_valid, 0);
        chk("rst_tx_data", ifc.tx_data, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_abort", ifc.abort, 0);
        chk("rst_in_ready", ifc.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_gnt", ifc.gnt, 0);

        // Round-robin table: each round's req is applied the cycle after the previous release.
        uart_hold = 3;
        for (int i = 0; i < 15; i++) begin
            ifc.req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("rr_gnt_%0d", i), ifc.gnt, tbl[i].exp_gnt);
            chk($sformatf("rr_busy_%0d", i), ifc.busy, 1);
            send_byte(tbl[i].src, tbl[i].b0, 1'b0);
            send_byte(tbl[i].src, tbl[i].b1, 1'b1);
            chk($sformatf("rr_release_%0d", i), {ifc.busy, ifc.gnt}, 0);
        end
        ifc.req = '0;

        // Single 3-byte message with a slow uart.
        uart_hold = 20;
        repeat (25) @(negedge clk);
        base = rdy_cnt[0];
        nlog = tx_log.size();
        msg[0] = 8'h52; msg[1] = 8'h6F; msg[2] = 8'h0A;
        ifc.req = 4'b0001;
        @(negedge clk);
        chk("msg_gnt_latency", ifc.gnt, 4'b0001);
        send_byte(0, msg[0], 1'b0);
        send_byte(0, msg[1], 1'b0);
        send_byte(0, msg[2], 1'b1);
        ifc.req = '0;
        chk("msg_end_gnt", ifc.gnt, 0);
        chk("msg_end_busy", ifc.busy, 0);
        chk("msg_last_pulse", {ifc.tx_valid, ifc.tx_data}, {1'b1, 8'h0A});
        repeat (3) @(negedge clk);
        chk("msg_in_ready_cycles", rdy_cnt[0] - base, 3);
        chk("msg_tx_count", tx_log.size() - nlog, 3);
        for (int i = 0; i < 3; i++)
            if (tx_log.size() > nlog + i) chk($sformatf("msg_byte%0d", i), tx_log[nlog + i], msg[i]);

        // Timeout: source 1 sends one byte then goes silent with tx_ready high.
        uart_hold = 0;
        repeat (25) @(negedge clk);
        ifc.req = 4'b0110;
        @(negedge clk);
        chk("to_gnt", ifc.gnt, 4'b0010);
        send_byte(1, 8'h5A, 1'b0);
        ab_cnt = 0; ab_at = -1; ab_gnt = '1; ab_busy = 1'b1; nxt_gnt = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ifc.abort) begin
                ab_cnt++;
                ab_at = k;
                ab_gnt = ifc.gnt;
                ab_busy = ifc.busy;
            end
            if (k == 10) nxt_gnt = ifc.gnt;
        end
        chk("to_abort_count", ab_cnt, 1);
        chk("to_abort_cycle", ab_at, 9);
        chk("to_abort_gnt", ab_gnt, 0);
        chk("to_abort_busy", ab_busy, 0);
        chk("to_next_gnt", nxt_gnt, 4'b0100);
        send_byte(2, 8'hC3, 1'b1);
        ifc.req = '0;
        chk("to_src2_release", ifc.gnt, 0);

        // Single-byte message with tx_ready already high; waiting requester regranted immediately.
        @(negedge clk);
        ifc.req = 4'b1010;
        @(negedge clk);
        chk("sb_gnt", ifc.gnt, 4'b1000);
        send_byte(3, 8'h99, 1'b1);
        ifc.req = 4'b0010;
        chk("sb_release_gnt", ifc.gnt, 0);
        chk("sb_pulse", {ifc.tx_valid, ifc.tx_data}, {1'b1, 8'h99});
        @(negedge clk);
        chk("sb_regrant", ifc.gnt, 4'b0010);
        chk("sb_single_pulse", ifc.tx_valid, 0);
        send_byte(1, 8'h77, 1'b1);
        ifc.req = '0;

        // Reset between the 2nd and 3rd byte of a message.
        repeat (5) @(negedge clk);
        uart_hold = 20;
        ifc.req = 4'b0001;
        @(negedge clk);
        chk("mr_gnt", ifc.gnt, 4'b0001);
        ifc.req = '0;
        send_byte(0, 8'hD1, 1'b0);
        send_byte(0, 8'hD2, 1'b0);
        rst = 1'b1;
        ifc.in_data[7:0] = 8'hD3;
        ifc.in_valid[0] = 1'b1;
        ifc.in_last[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_gnt_after_rst", ifc.gnt, 0);
        chk("mr_tx_valid_after_rst", ifc.tx_valid, 0);
        chk("mr_busy_after_rst", ifc.busy, 0);
        chk("mr_tx_data_after_rst", ifc.tx_data, 0);
        nlog = tx_log.size();
        base = rdy_cnt[0];
        repeat (30) @(negedge clk);
        chk("mr_no_third_byte", tx_log.size() - nlog, 0);
        chk("mr_no_ready", rdy_cnt[0] - base, 0);
        ifc.in_valid[0] = 1'b0;
        ifc.in_last[0] = 1'b0;
        ifc.req = 4'b0100;
        @(negedge clk);
        chk("mr_regrant_src2", ifc.gnt, 4'b0100);
        send_byte(2, 8'hE5, 1'b1);
        ifc.req = '0;

        repeat (30) @(negedge clk);
        chk("tx_total", tx_log.size(), exp_tx.size());
        mism = 0;
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            if (tx_log[i] !== exp_tx[i]) mism++;
        chk("tx_stream_order", mism, 0);
        chk("protocol_violations", proto_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
